hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WB_DIST, default 3: cycles from issue edge until the register-file write completes; legal range 1-3.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 d_valid  in  1  decode stage holds a real instruction, not a bubble.
REQ-006 d_icode  in  4  Y86 icode in decode.
REQ-007 d_srcA, d_srcB  in  4 each  decode source registers; 4'hF means none.
REQ-008 d_dstE, d_dstM  in  4 each  decode destination registers; 4'hF means none.
REQ-009 e_mispredict  in  1  execute has resolved a mispredicted jXX this cycle.
REQ-010 f_stall, d_stall  out  1 each  hold the F and D pipeline registers.
REQ-011 d_bubble, e_bubble  out  1 each  load a bubble into the D and E pipeline registers at the next edge.
REQ-012 issue  out  1  the decode instruction advances to E at this edge.
REQ-013 stall_cnt  out  CNT_W  number of cycles with d_stall=1.

Function
REQ-014 Scoreboard: one counter per register 0-14, width 2, plus one load flag per register.
REQ-015 On an issue cycle, the counter of each non-F destination is set to WB_DIST. The load flag of d_dstM is set to 1; the load flag of d_dstE is set to 0. If both destinations name the same register, d_dstM wins.
REQ-016 Every nonzero counter that is not being set in the same cycle decrements by 1 per cycle. When a counter reaches 0, its load flag clears.
REQ-017 Data hazard (hz) = d_valid AND a non-F d_srcA or d_srcB matches a register that meets the hazard condition in Configuration.
REQ-018 Return FSM states: R_IDLE, R_E, R_M, R_W.
  - R_IDLE -> R_E on issue with d_icode=4'h9.
  - R_E -> R_M -> R_W -> R_IDLE, one state per cycle, unconditionally.
REQ-019 Output priority, highest first:
  - e_mispredict: d_bubble=1, e_bubble=1, f_stall=0, d_stall=0, issue=0.
  - hz: f_stall=1, d_stall=1, e_bubble=1, d_bubble=0, issue=0.
  - FSM not in R_IDLE: d_bubble=1, issue=0; f_stall=1 in R_E and R_M; f_stall=0 in R_W.
  - ret in D in R_IDLE (d_valid, d_icode=9): f_stall=1, issue=1.
  - otherwise: issue=d_valid; all other outputs 0.
REQ-020 When issue=0, the scoreboard takes no new entries and the FSM does not leave R_IDLE.
REQ-021 All outputs except stall_cnt are combinational from state and inputs, with zero-cycle latency.
REQ-022 stall_cnt increments in every cycle with d_stall=1 and saturates at all-ones.
REQ-023 A simultaneous hz and ret in D resolves as a stall; the ret issues in a later cycle.

Reset
REQ-024 While reset=1:
  - all counters, load flags and stall_cnt clear to 0, and the FSM goes to R_IDLE;
  - outputs are d_bubble=1, e_bubble=1, f_stall=0, d_stall=0, issue=0.
REQ-025 A reset asserted in R_E, R_M or R_W returns the FSM to R_IDLE at the next edge; the pending ret is discarded.

Configuration
REQ-026 Macro HAZARD_FWD_EN.
  - Defined (forwarding present): a register meets the hazard condition only when its counter equals WB_DIST and its load flag is 1, i.e. a 1-cycle load-use stall.
  - Undefined: a register meets the hazard condition whenever its counter is nonzero, i.e. a stall until writeback.

Verification
REQ-027 Reset for 2 cycles -> d_bubble=1, e_bubble=1, issue=0; after release, stall_cnt=0 and FSM=R_IDLE.
REQ-028 Forwarding enabled: issue mrmovq (icode 5) with dstM=3, then opq with srcA=3 -> exactly 1 cycle of f_stall=d_stall=e_bubble=1, stall_cnt=1, then issue=1.
REQ-029 Forwarding disabled: irmovq (icode 3) with dstE=2, then rrmovq with srcA=2 -> 3 cycles of d_stall=1, issue=1 in the 4th cycle, stall_cnt=3.
REQ-030 Issue ret (icode 9) -> f_stall=1 on the issue cycle and the next 2 cycles; d_bubble=1 for 3 cycles; FSM returns to R_IDLE on the 4th edge.
REQ-031 e_mispredict=1 while a ret with a hazard sits in D -> d_bubble=1, e_bubble=1, d_stall=0, issue=0; FSM stays R_IDLE and stall_cnt is unchanged.
REQ-032 Set CNT_W=2 and force 5 hazard cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Y86 pipeline hazard control: register scoreboard, ret sequencing, stall counting.
// Define HAZARD_FWD_EN when forwarding exists, so only load-use stalls remain.
module hazard_ctrl #(
    parameter int WB_DIST = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic             e_mispredict,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             issue,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {R_IDLE, R_E, R_M, R_W} ret_state_e;

    localparam logic [1:0] WB = WB_DIST[1:0];
    localparam logic [3:0] I_RET = 4'h9;

    ret_state_e       state_q, state_d;
    logic [14:0][1:0] cnt_q, cnt_d;
    logic [14:0]      ld_q, ld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]      busy;
    logic             hz;
    logic             ret_in_d;

    // Register 15 (4'hF) never appears busy, so "none" sources never match.
    always_comb begin
        busy = '0;
        for (int r = 0; r < 15; r++) begin
`ifdef HAZARD_FWD_EN
            busy[r] = (cnt_q[r] == WB) && ld_q[r];
`else
            busy[r] = (cnt_q[r] != 2'd0);
`endif
        end
    end

    assign hz       = d_valid && (busy[d_srcA] || busy[d_srcB]);
    assign ret_in_d = d_valid && (d_icode == I_RET);

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        issue    = 1'b0;
        if (reset || e_mispredict) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
        end else if (hz) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end else if (state_q != R_IDLE) begin
            d_bubble = 1'b1;
            f_stall  = (state_q != R_W);
        end else if (ret_in_d) begin
            f_stall = 1'b1;
            issue   = 1'b1;
        end else begin
            issue = d_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_IDLE: if (issue && d_icode == I_RET) state_d = R_E;
            R_E:    state_d = R_M;
            R_M:    state_d = R_W;
            R_W:    state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // dstM is checked first so a shared destination keeps its load flag.
    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        for (int r = 0; r < 15; r++) begin
            if (issue && d_dstM == r[3:0]) begin
                cnt_d[r] = WB;
                ld_d[r]  = 1'b1;
            end else if (issue && d_dstE == r[3:0]) begin
                cnt_d[r] = WB;
                ld_d[r]  = 1'b0;
            end else if (cnt_q[r] != 2'd0) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
                if (cnt_q[r] == 2'd1) ld_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (d_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= R_IDLE;
            cnt_q       <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_q        <= ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations adapt to HAZARD_FWD_EN.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam int NE = 0;
    localparam int NM = 1;
`else
    localparam int NE = 3;
    localparam int NM = 3;
`endif
    localparam logic [3:0] F = 4'hF;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_icode, d_srcA, d_srcB, d_dstE, d_dstM;
    logic        e_mispredict;
    logic        f_stall, d_stall, d_bubble, e_bubble, issue;
    logic [15:0] stall_cnt;
    logic        f2, d2, db2, eb2, is2;
    logic [1:0]  stall_cnt2;
    logic [4:0]  outs;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clock = ~clock;

    hazard_ctrl dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_icode(d_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .e_mispredict(e_mispredict), .f_stall(f_stall), .d_stall(d_stall),
        .d_bubble(d_bubble), .e_bubble(e_bubble), .issue(issue),
        .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_icode(d_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .e_mispredict(e_mispredict), .f_stall(f2), .d_stall(d2),
        .d_bubble(db2), .e_bubble(eb2), .issue(is2),
        .stall_cnt(stall_cnt2)
    );

    assign outs = {f_stall, d_stall, d_bubble, e_bubble, issue};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] ic, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [3:0] de,
                       input logic [3:0] dm, input logic mis);
        d_valid = v; d_icode = ic; d_srcA = sa; d_srcB = sb;
        d_dstE = de; d_dstM = dm; e_mispredict = mis;
    endtask

    // exp bits: f_stall d_stall d_bubble e_bubble issue
    task automatic cyc(input string tag, input logic [4:0] exp);
        #1;
        check(tag, 32'(outs), 32'(exp));
        if (exp[3] && !reset) exp_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        check({tag, "_cnt2"}, 32'(stall_cnt2), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
    endtask

    task automatic idle(input int n);
        drv(1'b0, 4'h1, F, F, F, F, 1'b0);
        for (int i = 0; i < n; i++) cyc("idle", 5'b00000);
    endtask

    task automatic dep(input string tag, input logic [3:0] pic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [3:0] sa, input int n);
        drv(1'b1, pic, F, F, de, dm, 1'b0);
        cyc({tag, "_prod"}, 5'b00001);
        drv(1'b1, 4'h6, sa, F, F, F, 1'b0);
        for (int i = 0; i < n; i++) cyc({tag, "_stall"}, 5'b11010);
        cyc({tag, "_use"}, 5'b00001);
        idle(3);
        chk_cnt(tag);
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b1, 4'h6, F, F, F, F, 1'b0);
        cyc("rst0", 5'b00110);
        cyc("rst1", 5'b00110);
        reset = 1'b0;
        chk_cnt("rst");
        idle(1);

        dep("alu_use", 4'h3, 4'h2, F, 4'h2, NE);
        dep("load_use", 4'h5, F, 4'h3, 4'h3, NM);
        dep("same_dst", 4'hB, 4'h7, 4'h7, 4'h7, NM);
        dep("no_dep", 4'h3, 4'h1, F, F, 0);

        drv(1'b1, 4'h9, F, F, F, F, 1'b0);
        cyc("ret_iss", 5'b10001);
        drv(1'b1, 4'h6, F, F, F, F, 1'b0);
        cyc("ret_e", 5'b10100);
        cyc("ret_m", 5'b10100);
        cyc("ret_w", 5'b00100);
        cyc("ret_done", 5'b00001);
        idle(3);
        chk_cnt("ret");

        drv(1'b1, 4'h5, F, F, F, 4'h3, 1'b0);
        cyc("hzret_prod", 5'b00001);
        drv(1'b1, 4'h9, 4'h3, F, F, F, 1'b0);
        for (int i = 0; i < NM; i++) cyc("hzret_stall", 5'b11010);
        cyc("hzret_iss", 5'b10001);
        idle(0);
        drv(1'b0, 4'h1, F, F, F, F, 1'b0);
        cyc("hzret_e", 5'b10100);
        cyc("hzret_m", 5'b10100);
        cyc("hzret_w", 5'b00100);
        idle(3);
        chk_cnt("hzret");

        drv(1'b1, 4'h5, F, F, F, 4'h3, 1'b0);
        cyc("mis_prod", 5'b00001);
        drv(1'b1, 4'h9, 4'h3, F, F, F, 1'b1);
        cyc("mis", 5'b00110);
        idle(3);
        chk_cnt("mis");
        drv(1'b1, 4'h9, F, F, F, F, 1'b0);
        cyc("mis_idle", 5'b10001);
        idle(0);
        drv(1'b0, 4'h1, F, F, F, F, 1'b0);
        cyc("mis_re", 5'b10100);
        cyc("mis_rm", 5'b10100);
        cyc("mis_rw", 5'b00100);
        idle(1);

        drv(1'b1, 4'h9, F, F, F, F, 1'b0);
        cyc("rret_iss", 5'b10001);
        reset = 1'b1;
        cyc("rret_rst", 5'b00110);
        reset = 1'b0;
        exp_cnt = 0;
        drv(1'b1, 4'h6, F, F, F, F, 1'b0);
        cyc("rret_idle", 5'b00001);
        idle(1);
        chk_cnt("rret");

        for (int k = 0; k < 5; k++) dep("sat", 4'h5, F, 4'h3, 4'h3, NM);
        check("sat_final", 32'(stall_cnt2), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
